// File: rtl/mrv1_tw_barrier.sv
// ============================================================================
// mrv1_tw_barrier : warp barrier table, stalls arrived warps until a barrier fills
// Revision 1.0
// ============================================================================
`default_nettype none

module mrv1_tw_barrier #(
    parameter  int NUM_TW_P            = 8,
    parameter  int num_barriers_p      = 8,
    localparam int wid_width_lp        = $clog2(NUM_TW_P),
    localparam int barrier_id_width_lp = $clog2(num_barriers_p)
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic                           bar_req_i,
    output logic                           bar_rdy_o,
    input  logic [barrier_id_width_lp-1:0] bar_id_i,
    input  logic [wid_width_lp-1:0]        bar_size_m1_i,
    input  logic [wid_width_lp-1:0]        bar_wid_i,
    input  logic                           flush_i,
    output logic                           rel_vld_o,
    output logic [barrier_id_width_lp-1:0] rel_id_o,
    output logic [NUM_TW_P-1:0]            rel_wmask_o,
    output logic [NUM_TW_P-1:0]            stall_wmask_o,
    output logic [num_barriers_p-1:0]      active_o,
    output logic                           err_o
);

    localparam int CNT_W = wid_width_lp + 1;

    logic [num_barriers_p-1:0] r_vld;
    logic [wid_width_lp-1:0]   r_size [num_barriers_p];
    logic [NUM_TW_P-1:0]       r_mask [num_barriers_p];

    logic                    w_accept;
    logic [NUM_TW_P-1:0]     w_onehot;
    logic                    w_cur_vld;
    logic [wid_width_lp-1:0] w_cur_size;
    logic [NUM_TW_P-1:0]     w_cur_mask;
    logic                    w_dup;
    logic                    w_mismatch;
    logic [NUM_TW_P-1:0]     w_new_mask;
    logic [wid_width_lp-1:0] w_eff_size;
    logic [CNT_W-1:0]        w_count;
    logic                    w_complete;
    logic [NUM_TW_P-1:0]     w_stall;

    assign bar_rdy_o = ~flush_i;
    assign w_accept  = bar_req_i & ~flush_i;

    always_comb begin
        w_onehot   = NUM_TW_P'(1) << bar_wid_i;
        w_cur_vld  = r_vld[bar_id_i];
        w_cur_size = r_size[bar_id_i];
        w_cur_mask = r_mask[bar_id_i];
        w_dup      = w_cur_vld & (|(w_cur_mask & w_onehot));
        w_mismatch = w_cur_vld & (bar_size_m1_i != w_cur_size);
        w_new_mask = (w_cur_vld ? w_cur_mask : '0) | w_onehot;
        // A valid entry keeps the size it latched at first arrival
        w_eff_size = w_cur_vld ? w_cur_size : bar_size_m1_i;
        w_count    = '0;
        for (int i = 0; i < NUM_TW_P; i++) begin
            w_count = w_count + CNT_W'(w_new_mask[i]);
        end
        w_complete = w_accept & (w_count == (CNT_W'(w_eff_size) + CNT_W'(1)));
    end

    always_comb begin
        w_stall = '0;
        for (int i = 0; i < num_barriers_p; i++) begin
            if (r_vld[i]) begin
                w_stall = w_stall | r_mask[i];
            end
        end
    end

    assign stall_wmask_o = w_stall;
    assign active_o      = r_vld;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_vld       <= '0;
            rel_vld_o   <= 1'b0;
            rel_id_o    <= '0;
            rel_wmask_o <= '0;
            err_o       <= 1'b0;
            for (int i = 0; i < num_barriers_p; i++) begin
                r_size[i] <= '0;
                r_mask[i] <= '0;
            end
        end else if (flush_i) begin
            r_vld       <= '0;
            rel_vld_o   <= 1'b0;
            rel_id_o    <= '0;
            rel_wmask_o <= '0;
            err_o       <= 1'b0;
            for (int i = 0; i < num_barriers_p; i++) begin
                r_size[i] <= '0;
                r_mask[i] <= '0;
            end
        end else begin
            rel_vld_o   <= w_complete;
            rel_id_o    <= w_complete ? bar_id_i : '0;
            rel_wmask_o <= w_complete ? w_new_mask : '0;
            err_o       <= w_accept & (w_dup | w_mismatch);
            if (w_accept && !w_dup) begin
                // A completing arrival retires the entry in the same edge
                if (w_complete) begin
                    r_vld[bar_id_i]  <= 1'b0;
                    r_mask[bar_id_i] <= '0;
                    r_size[bar_id_i] <= '0;
                end else begin
                    r_vld[bar_id_i]  <= 1'b1;
                    r_mask[bar_id_i] <= w_new_mask;
                    if (!w_cur_vld) begin
                        r_size[bar_id_i] <= bar_size_m1_i;
                    end
                end
            end
        end
    end

endmodule

`default_nettype wire
